// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_frame_pkg
// Shared definitions for the UART receive frame controller: FSM state
// encoding, error codes reported on Err_Code, the default start-of-frame
// marker and a helper that checks a received LEN byte against the payload
// buffer depth.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_PAY   = 3'd2,
    S_CHK   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'h55;

  // A LEN byte is usable only if it is non-zero and fits the payload buffer.
  function automatic logic len_is_legal(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if
// Bundles the receiver-side byte strobe, the receiver enable, the payload
// stream towards the command decoder and the error/status outputs.
//   Rx_Done_Sig  one-cycle strobe per byte from uart_rx
//   Rx_Data      received byte, valid with Rx_Done_Sig
//   Rx_En_Sig    enable back to uart_rx
//   Out_Valid / Out_Ready / Out_Data / Out_Last  payload byte stream
//   Frame_Err    one-cycle error pulse, Err_Code holds the last error cause
//   Busy         controller is inside a frame or draining one
// master: the frame controller. slave: receiver + consumer side.
interface uart_rx_frame_ctrl_if;

  logic       Rx_Done_Sig;
  logic [7:0] Rx_Data;
  logic       Rx_En_Sig;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [7:0] Out_Data;
  logic       Out_Last;
  logic       Frame_Err;
  logic [1:0] Err_Code;
  logic       Busy;

  modport master (
    input  Rx_Done_Sig, Rx_Data, Out_Ready,
    output Rx_En_Sig, Out_Valid, Out_Data, Out_Last, Frame_Err, Err_Code, Busy
  );

  modport slave (
    output Rx_Done_Sig, Rx_Data, Out_Ready,
    input  Rx_En_Sig, Out_Valid, Out_Data, Out_Last, Frame_Err, Err_Code, Busy
  );

endinterface

// File: rtl/uart_rx_frame_ctrl_timer.sv
// uart_frame_timer
// Inter-byte timer. Counts while en_i is high, clears on clr_i. expire_o is
// high for the single cycle in which the count sits at TIMEOUT_CLKS-1 and no
// clear is requested, so a byte arriving on the terminal cycle suppresses it.
//   CLK, RST   clock and synchronous active-high reset
//   clr_i      clear the count (byte received or controller idle)
//   en_i       count this cycle
//   expire_o   terminal count reached
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CLKS = 17360
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] count_q;

  assign expire_o = en_i && !clr_i && (count_q == TERM);

  // Restart after expiry so the count never runs past the terminal value.
  always_ff @(posedge CLK) begin
    if (RST || clr_i || expire_o) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + TW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frames the byte stream coming out of uart_rx: SOF, LEN, LEN payload bytes,
// checksum (XOR of LEN and payload). Good payloads are buffered and then
// streamed out over valid/ready with Out_Last on the final byte; the receiver
// is disabled while draining. Bad LEN, checksum mismatch and inter-byte
// timeout each raise a one-cycle Frame_Err and update Err_Code.
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset
//   bus  uart_rx_frame_ctrl_if.master (receiver, stream and status signals)
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SOF_BYTE     = DEFAULT_SOF_BYTE,
  parameter int unsigned TIMEOUT_CLKS = 17360
) (
  input logic                  CLK,
  input logic                  RST,
  uart_rx_frame_ctrl_if.master bus
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e        state_q;
  logic [IW-1:0] len_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    csum_q;
  logic [7:0]    buf_q [MAX_LEN];
  logic          rx_en_q;
  logic          out_valid_q;
  logic [7:0]    out_data_q;
  logic          out_last_q;
  logic          frame_err_q;
  logic [1:0]    err_code_q;
  logic          busy_q;

  logic          rx_done;
  logic [7:0]    rx_data;
  logic [IW-1:0] idx_inc;
  logic [IW-1:0] len_m1;
  logic          tmr_en;
  logic          tmr_clr;
  logic          tmo_expire;

  assign rx_done = bus.Rx_Done_Sig;
  assign rx_data = bus.Rx_Data;
  assign idx_inc = idx_q + IW'(1);
  assign len_m1  = len_q - IW'(1);

  assign tmr_en  = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CHK);
  assign tmr_clr = rx_done || (state_q == S_IDLE);

  uart_frame_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmo_expire)
  );

  // Payload storage; contents are meaningless until a frame fills them, so
  // no reset is needed.
  always_ff @(posedge CLK) begin
    if (state_q == S_PAY && rx_done) begin
      buf_q[idx_q[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      rx_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      busy_q      <= 1'b0;
    end else begin
      // Receiver stays enabled everywhere except while draining.
      rx_en_q     <= 1'b1;
      frame_err_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (rx_done && rx_data == SOF_BYTE) begin
            state_q <= S_LEN;
            busy_q  <= 1'b1;
            csum_q  <= '0;
          end
        end

        S_LEN: begin
          if (rx_done) begin
            if (!len_is_legal(rx_data, MAX_LEN)) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
            end else begin
              len_q   <= rx_data[IW-1:0];
              csum_q  <= rx_data;
              idx_q   <= '0;
              state_q <= S_PAY;
            end
          end else if (tmo_expire) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TMO;
          end
        end

        S_PAY: begin
          if (rx_done) begin
            csum_q <= csum_q ^ rx_data;
            idx_q  <= idx_inc;
            if (idx_q == len_m1) begin
              state_q <= S_CHK;
            end
          end else if (tmo_expire) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TMO;
          end
        end

        S_CHK: begin
          if (rx_done) begin
            if (rx_data == csum_q) begin
              // Present the first payload byte straight away.
              state_q     <= S_DRAIN;
              rx_en_q     <= 1'b0;
              idx_q       <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= buf_q[0];
              out_last_q  <= (len_q == IW'(1));
            end else begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHK;
            end
          end else if (tmo_expire) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TMO;
          end
        end

        S_DRAIN: begin
          rx_en_q <= 1'b0;
          // Data/Last only move on an accepted transfer, so they hold under
          // backpressure.
          if (out_valid_q && bus.Out_Ready) begin
            if (out_last_q) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              rx_en_q     <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              idx_q      <= idx_inc;
              out_data_q <= buf_q[idx_inc[AW-1:0]];
              out_last_q <= (idx_inc == len_m1);
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Rx_En_Sig = rx_en_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Out_Data  = out_data_q;
  assign bus.Out_Last  = out_last_q;
  assign bus.Frame_Err = frame_err_q;
  assign bus.Err_Code  = err_code_q;
  assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl
// Directed frames drive the controller; expected payload bytes and error
// codes are queued when each frame is issued, and a negedge monitor pops and
// compares them as the DUT presents transfers and error pulses.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned TMO = 17360;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } out_t;

  logic CLK;
  logic RST;

  uart_rx_frame_ctrl_if bus ();

  uart_rx_frame_ctrl #(
    .MAX_LEN      (16),
    .SOF_BYTE     (8'h55),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  out_t       exp_out_q [$];
  logic [1:0] exp_err_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: sample on the falling edge, away from DUT updates.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (bus.Out_Valid === 1'b1 && bus.Out_Ready === 1'b1) begin
        $display("xfer data=%02h last=%0d", bus.Out_Data, bus.Out_Last);
        if (exp_out_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_xfer: got data %02h, expected no transfer", bus.Out_Data);
        end else begin
          out_t e;
          e = exp_out_q.pop_front();
          chk("xfer_data", 32'(bus.Out_Data), 32'(e.data));
          chk("xfer_last", 32'(bus.Out_Last), 32'(e.last));
        end
      end
      if (bus.Frame_Err === 1'b1) begin
        $display("frame_err code=%0d", bus.Err_Code);
        if (exp_err_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_err: got code %0d, expected no error", bus.Err_Code);
        end else begin
          logic [1:0] ec;
          ec = exp_err_q.pop_front();
          chk("err_code", 32'(bus.Err_Code), 32'(ec));
        end
      end
    end
  end

  // One Rx_Done pulse; returns #1 after the edge that sampled it.
  task automatic pulse(input logic [7:0] b);
    bus.Rx_Done_Sig = 1'b1;
    bus.Rx_Data     = b;
    @(posedge CLK); #1;
    bus.Rx_Done_Sig = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    pulse(b);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.Rx_Done_Sig = 1'b0;
    bus.Rx_Data     = 8'h00;
    bus.Out_Ready   = 1'b1;
    RST             = 1'b1;
    idle(3);

    // Reset state
    chk("rst_rx_en",     32'(bus.Rx_En_Sig), 0);
    chk("rst_out_valid", 32'(bus.Out_Valid), 0);
    chk("rst_out_data",  32'(bus.Out_Data),  0);
    chk("rst_frame_err", 32'(bus.Frame_Err), 0);
    chk("rst_err_code",  32'(bus.Err_Code),  0);
    chk("rst_busy",      32'(bus.Busy),      0);
    RST = 1'b0;
    idle(1);
    chk("rx_en_after_rst", 32'(bus.Rx_En_Sig), 1);

    // Good frame 55 03 11 22 33 03
    exp_out_q.push_back('{8'h11, 1'b0});
    exp_out_q.push_back('{8'h22, 1'b0});
    exp_out_q.push_back('{8'h33, 1'b1});
    rx_byte(8'h55); rx_byte(8'h03); rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    pulse(8'h03);
    chk("t1_valid",    32'(bus.Out_Valid), 1);
    chk("t1_data0",    32'(bus.Out_Data),  32'h11);
    chk("t1_rxen_low", 32'(bus.Rx_En_Sig), 0);
    chk("t1_busy",     32'(bus.Busy),      1);
    idle(2);
    chk("t1_last",     32'(bus.Out_Last),  1);
    chk("t1_data2",    32'(bus.Out_Data),  32'h33);
    chk("t1_rxen_low2", 32'(bus.Rx_En_Sig), 0);
    idle(1);
    chk("t1_valid_off", 32'(bus.Out_Valid), 0);
    chk("t1_rxen_back", 32'(bus.Rx_En_Sig), 1);
    chk("t1_idle",      32'(bus.Busy),      0);

    // Bad checksum 55 03 11 22 33 04
    exp_err_q.push_back(2'd2);
    rx_byte(8'h55); rx_byte(8'h03); rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    pulse(8'h04);
    chk("t2_err_pulse", 32'(bus.Frame_Err), 1);
    idle(1);
    chk("t2_err_width", 32'(bus.Frame_Err), 0);
    chk("t2_no_valid",  32'(bus.Out_Valid), 0);
    idle(3);
    chk("t2_code_held", 32'(bus.Err_Code), 2);
    // Next good frame: 55 02 A0 0B A9
    exp_out_q.push_back('{8'hA0, 1'b0});
    exp_out_q.push_back('{8'h0B, 1'b1});
    rx_byte(8'h55); rx_byte(8'h02); rx_byte(8'hA0); rx_byte(8'h0B); rx_byte(8'hA9);
    idle(2);

    // Bad length: 55 00, then 55 11
    exp_err_q.push_back(2'd1);
    rx_byte(8'h55); rx_byte(8'h00);
    chk("t3a_idle", 32'(bus.Busy), 0);
    exp_err_q.push_back(2'd1);
    rx_byte(8'h55); rx_byte(8'h11);
    chk("t3b_idle", 32'(bus.Busy), 0);
    chk("t3b_code", 32'(bus.Err_Code), 1);

    // Leading garbage + backpressure: AA 00 55 01 7E 7F
    bus.Out_Ready = 1'b0;
    rx_byte(8'hAA);
    chk("t4_garbage_idle", 32'(bus.Busy), 0);
    rx_byte(8'h00);
    rx_byte(8'h55); rx_byte(8'h01); rx_byte(8'h7E);
    exp_out_q.push_back('{8'h7E, 1'b1});
    pulse(8'h7F);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(bus.Out_Valid), 1);
      chk("t4_hold_data",  32'(bus.Out_Data),  32'h7E);
      chk("t4_hold_last",  32'(bus.Out_Last),  1);
      idle(1);
    end
    bus.Out_Ready = 1'b1;
    idle(1);
    chk("t4_done", 32'(bus.Out_Valid), 0);

    // Timeout: 55 02 11 then silence
    exp_err_q.push_back(2'd3);
    rx_byte(8'h55); rx_byte(8'h02);
    pulse(8'h11);
    n = 0;
    while (bus.Frame_Err !== 1'b1 && n < int'(TMO) + 10) begin
      idle(1);
      n++;
    end
    chk("t5_tmo_latency", 32'(n), 32'(TMO));
    idle(2);
    // Repeat, with a byte on the terminal cycle
    rx_byte(8'h55); rx_byte(8'h02);
    pulse(8'h11);
    repeat (TMO - 1) @(posedge CLK);
    #1;
    exp_out_q.push_back('{8'h11, 1'b0});
    exp_out_q.push_back('{8'h22, 1'b1});
    pulse(8'h22);
    chk("t5_no_tmo", 32'(bus.Frame_Err), 0);
    chk("t5_busy",   32'(bus.Busy),      1);
    rx_byte(8'h31);
    idle(2);

    // Reset mid-drain: 55 01 5A 5B with consumer stalled
    bus.Out_Ready = 1'b0;
    rx_byte(8'h55); rx_byte(8'h01); rx_byte(8'h5A);
    pulse(8'h5B);
    chk("t6_valid_before", 32'(bus.Out_Valid), 1);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    chk("t6_rx_en",     32'(bus.Rx_En_Sig), 0);
    chk("t6_valid",     32'(bus.Out_Valid), 0);
    chk("t6_last",      32'(bus.Out_Last),  0);
    chk("t6_data",      32'(bus.Out_Data),  0);
    chk("t6_frame_err", 32'(bus.Frame_Err), 0);
    chk("t6_err_code",  32'(bus.Err_Code),  0);
    chk("t6_busy",      32'(bus.Busy),      0);
    idle(1);
    chk("t6_rx_en_back", 32'(bus.Rx_En_Sig), 1);
    bus.Out_Ready = 1'b1;
    idle(4);

    chk("sb_out_empty", 32'(exp_out_q.size()), 0);
    chk("sb_err_empty", 32'(exp_err_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Sequences the UART receiver: drives its enable, collects received bytes into framed packets, and validates each frame. Frame format: SOF, LEN, LEN payload bytes, then a checksum, where checksum = XOR of LEN and all payload bytes. Valid payloads are buffered, then streamed to the command decoder over a valid/ready interface. Sits between uart_rx and the command layer, replacing the single-byte latch controller.

Parameters:
MAX_LEN, 16, payload buffer depth in bytes; legal LEN range is 1..MAX_LEN.
SOF_BYTE, 8'h55, start-of-frame marker.
TIMEOUT_CLKS, 17360, maximum CLK cycles allowed between bytes inside a frame.

Ports:
CLK  input  1  system clock, all logic on its rising edge
RST  input  1  synchronous, active-high reset
Rx_Done_Sig  input  1  one-cycle pulse per received byte, from uart_rx
Rx_Data  input  8  received byte, valid while Rx_Done_Sig=1
Rx_En_Sig  output  1  enable to uart_rx
Out_Valid  output  1  payload byte available
Out_Ready  input  1  consumer accepts byte
Out_Data  output  8  payload byte
Out_Last  output  1  marks final payload byte
Frame_Err  output  1  one-cycle error pulse
Err_Code  output  2  1=bad LEN, 2=checksum mismatch, 3=timeout; held until the next error
Busy  output  1  high in any state other than S_IDLE

Behaviour:
- Reset values (synchronous, RST=1): state=S_IDLE, Rx_En_Sig=0, Out_Valid=0, Out_Last=0, Out_Data=0, Frame_Err=0, Err_Code=0, Busy=0, timer=0, checksum=0, index=0.
- Rx_En_Sig is registered:
  - 1 from the first cycle after RST deasserts, in S_IDLE/S_LEN/S_PAY/S_CHK.
  - 0 throughout S_DRAIN; bytes arriving then are lost by protocol (half-duplex command link).
- S_IDLE:
  - Rx_Done_Sig with Rx_Data==SOF_BYTE: go to S_LEN, clear checksum.
  - Any other byte: discarded silently, no error.
- S_LEN, on Rx_Done_Sig:
  - LEN==0 or LEN>MAX_LEN: Frame_Err pulse, Err_Code=1, go to S_IDLE.
  - Otherwise: store LEN, checksum=LEN, index=0, go to S_PAY.
- S_PAY, each Rx_Done_Sig: buf[index]=byte, checksum^=byte, index++. When index reaches LEN-1 and that byte is received, go to S_CHK.
- S_CHK, on Rx_Done_Sig:
  - byte==checksum: go to S_DRAIN, index=0.
  - Otherwise: Frame_Err pulse, Err_Code=2, go to S_IDLE.
- Timeout:
  - Timer clears on every Rx_Done_Sig and in S_IDLE; it counts only in S_LEN/S_PAY/S_CHK.
  - Reaching TIMEOUT_CLKS-1: Frame_Err pulse, Err_Code=3, go to S_IDLE.
  - Rx_Done_Sig in the same cycle as the terminal count: the byte wins and no timeout fires.
- S_DRAIN:
  - Out_Valid=1 from the cycle after the checksum byte is sampled; Out_Data=buf[index].
  - Out_Last=1 when index==LEN-1.
  - On Out_Valid&&Out_Ready: index++. On the last byte, go to S_IDLE with Out_Valid=0 in the next cycle.
  - Out_Data and Out_Last stay stable while Out_Valid=1 and Out_Ready=0.
- Frame_Err timing: asserts the cycle after the offending byte, or the cycle after timer expiry; exactly one cycle wide.
- SOF_BYTE received inside S_LEN/S_PAY/S_CHK is ordinary data; there is no resynchronisation.
- Reset mid-frame or mid-drain: abandon everything and return to reset values; no Frame_Err.
- Widths: index and LEN use clog2(MAX_LEN+1) bits; timer uses clog2(TIMEOUT_CLKS) bits.

Decomposition:
- Package uart_frame_pkg holds:
  - state encoding S_IDLE, S_LEN, S_PAY, S_CHK, S_DRAIN;
  - error codes ERR_NONE=0, ERR_LEN=1, ERR_CHK=2, ERR_TMO=3;
  - default SOF_BYTE.
- One sub-module, uart_frame_timer: inter-byte timer with clear/enable inputs and a one-cycle expire output, parameterised by TIMEOUT_CLKS.
- Payload buffer stays inline as a register array.

Test Plan:
- Good frame: bytes 55 03 11 22 33 03, Out_Ready=1 -> Out_Data 11,22,33 on consecutive cycles; Out_Last only on 33; Rx_En_Sig low during drain, high one cycle after the last transfer.
- Bad checksum: 55 03 11 22 33 04 -> Frame_Err one cycle, Err_Code=2, Out_Valid never asserts; the next good frame is accepted.
- Bad length: 55 00, then separately 55 11 (17 > MAX_LEN) -> Err_Code=1 each time, return to S_IDLE.
- Leading garbage plus backpressure: AA 00 55 01 7E 7F with Out_Ready low for 5 cycles -> no error; Out_Data=7E held for 5 cycles; Out_Last=1; one transfer.
- Timeout: 55 02 11 then silence -> Frame_Err exactly TIMEOUT_CLKS cycles after the 11 pulse, Err_Code=3. A repeat run delivers a byte on the terminal cycle -> no error.
- Reset mid-drain: RST for 1 cycle while Out_Valid=1 -> all outputs return to reset values next cycle; Rx_En_Sig=1 the cycle after RST deasserts.
